axi_ddr_responder: RTL and testbench
====================================

// Module: axi_ddr_responder
// PURPOSE
//  AXI4 slave, BRAM-backed; the responder end of the 512-bit DDR master port driven by mem_single_inf.
//  Stands in for the DDR controller in DDR-less builds and in closed-loop benches, so memory traffic from the user role is answered on-chip.
//  One outstanding write and one outstanding read.
//  Read and write channels are serviced concurrently.
// PARAMETERS
//  AXI_ID_WIDTH    1    width of awid/bid/arid/rid
//  ADDR_WIDTH      32   byte-address width
//  DATA_WIDTH      512  data width; byte lanes = DATA_WIDTH/8
//  MEM_DEPTH_LOG2  10   log2 of the number of DATA_WIDTH words in backing RAM
// PORTS
//  aclk            in   1   single clock
//  areset          in   1   synchronous, active-high reset
//  s_axi_aw{id,addr,len,size,burst}  in  ID/ADDR/8/3/2  write address; lock/cache/prot are accepted and ignored
//  s_axi_awvalid   in   1    / s_axi_awready  out 1
//  s_axi_wdata     in   DATA_WIDTH
//  s_axi_wstrb     in   DATA_WIDTH/8
//  s_axi_wlast     in   1    / s_axi_wvalid in 1 / s_axi_wready out 1
//  s_axi_bid       out  ID   / s_axi_bresp out 2 / s_axi_bvalid out 1 / s_axi_bready in 1
//  s_axi_ar{id,addr,len,size,burst}  in  ID/ADDR/8/3/2  read address
//  s_axi_arvalid   in   1    / s_axi_arready  out 1
//  s_axi_rid       out  ID   / s_axi_rdata out DATA_WIDTH / s_axi_rresp out 2
//  s_axi_rlast     out  1    / s_axi_rvalid out 1 / s_axi_rready in 1
// BEHAVIOUR
//  Reset
//   - While areset=1, all outputs are 0 (including awready and arready); both FSMs go to IDLE.
//   - RAM contents are NOT cleared.
//   - Reset mid-burst abandons the burst; no B or R is produced for it.
//   - awready/arready rise on the first cycle after areset falls.
//  Word index: idx = addr[ADDR_LSB +: MEM_DEPTH_LOG2], where ADDR_LSB = log2(DATA_WIDTH/8).
//   - Address bits above the index must be 0, otherwise the burst is out of range: DECERR (2'b11).
//   - INCR: idx+1 per beat, wrapping modulo 2^MEM_DEPTH_LOG2 with no error. FIXED: idx held.
//   - WRAP, burst=3, or size != ADDR_LSB: SLVERR (2'b10). The beats are still consumed or produced.
//  Write FSM: W_IDLE -> W_DATA -> W_RESP
//   - W_IDLE: awready=1. On handshake, latch id, idx, len, err; go to W_DATA.
//   - W_DATA: wready=1. Each accepted beat writes the RAM, honouring wstrb; nothing is written if err.
//   - Beat counter runs 0..len. Leave W_DATA on beat==len, regardless of wlast.
//   - Any beat where wlast != (beat==len) sets SLVERR, unless DECERR is already set.
//   - W_RESP: bvalid=1 and bresp are registered; bvalid rises the cycle after the last W beat. Hold until bready, then W_IDLE.
//  Read FSM: R_IDLE -> R_DATA
//   - R_IDLE: arready=1. On handshake, latch fields and go to R_DATA.
//   - R_DATA: the RAM read has 1-cycle latency into a 2-entry output skid buffer.
//   - A RAM read is issued only when the skid buffer has room for its result.
//   - First rvalid at T+2 after the AR handshake at T.
//   - Sustains 1 beat/cycle while rready=1; rvalid/rdata/rlast/rresp stay stable while stalled.
//   - rlast on beat len. rdata=0 for an out-of-range burst.
//   - Return to R_IDLE when the last beat is accepted. The next arready comes the following cycle.
//  Same-cycle read and write to the same word: read-first; R returns the old data.
//  B and R never block each other.
//  len=0 (1 beat) must work on both channels.
// STRUCTURE
//  Package axi_mem_pkg:
//   - BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR/DECERR
//   - wr_state_t {W_IDLE,W_DATA,W_RESP}, rd_state_t {R_IDLE,R_DATA}
//  Sub-module axi_mem_ram: simple dual-port RAM, 1 write port with byte enables, 1 registered read port, read-first.
//  Both FSMs and the skid buffer live in this module.
// TESTING
//  1 Write awaddr=0x40, len=3, INCR, full strobes, data D0..D3; then read the same burst -> bresp=0, 4 R beats D0..D3, rlast on beat 3, rresp=0.
//  2 Partial write: wstrb=0x...000F over word 0xAA..A, then read -> only low 4 bytes changed.
//  3 Backpressure: read len=7 with rready toggling 1,0,0,1,... -> 8 ordered beats, no drop or duplicate, outputs stable while stalled.
//  4 Errors:
//     - araddr = 1<<(ADDR_LSB+MEM_DEPTH_LOG2) -> DECERR on all beats, rdata=0.
//     - awlen=1 with wlast on beat 0 -> bresp=SLVERR, FSM returns to W_IDLE.
//  5 Concurrency and wrap:
//     - Read and write to idx 5 in the same cycle -> read returns the old value.
//     - INCR burst starting at idx 2^MEM_DEPTH_LOG2-1, len=1 -> second beat lands at idx 0.
//  6 Reset mid-burst: areset during W_DATA beat 2 -> bvalid stays 0; awready=1 one cycle after release; RAM keeps prior data.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared AXI encodings and FSM state types for the BRAM-backed AXI responder.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, read-first on collision.
module axi_mem_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_ddr_responder.sv
// AXI4 slave answering the DDR master port from on-chip RAM; one write and one read burst in flight.
module axi_ddr_responder
    import axi_mem_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 512,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
    localparam int TOP_LSB  = ADDR_LSB + MEM_DEPTH_LOG2;
    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

    function automatic logic [1:0] burst_resp(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [1:0] burst, input logic [2:0] size);
        if ((addr >> TOP_LSB) != '0) return RESP_DECERR;
        if (burst == BURST_WRAP || burst == 2'b11 || size != 3'(ADDR_LSB)) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + idx_t'(1);
    endfunction

    // Write channel
    wr_state_t                 w_state, w_next;
    logic [AXI_ID_WIDTH-1:0]   w_id;
    idx_t                      w_idx;
    logic [7:0]                w_len, w_beat;
    logic [1:0]                w_burst, w_resp;
    logic                      w_ok, aw_hs, w_hs, w_final;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign w_final = (w_beat == w_len);

    always_ff @(posedge aclk) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (aw_hs) w_next = W_DATA;
            W_DATA: if (w_hs && w_final) w_next = W_RESP;
            W_RESP: if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (w_state == W_IDLE) && !areset;
        s_axi_wready  = (w_state == W_DATA) && !areset;
        s_axi_bvalid  = (w_state == W_RESP) && !areset;
        s_axi_bid     = s_axi_bvalid ? w_id : '0;
        s_axi_bresp   = s_axi_bvalid ? w_resp : RESP_OKAY;
    end

    // A wlast mismatch downgrades to SLVERR but never masks an earlier DECERR
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_id    <= s_axi_awid;
            w_idx   <= s_axi_awaddr[ADDR_LSB +: MEM_DEPTH_LOG2];
            w_len   <= s_axi_awlen;
            w_burst <= s_axi_awburst;
            w_resp  <= burst_resp(s_axi_awaddr, s_axi_awburst, s_axi_awsize);
            w_ok    <= (burst_resp(s_axi_awaddr, s_axi_awburst, s_axi_awsize) == RESP_OKAY);
            w_beat  <= '0;
        end else if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            w_idx  <= next_idx(w_idx, w_burst);
            if ((s_axi_wlast != w_final) && (w_resp != RESP_DECERR)) w_resp <= RESP_SLVERR;
        end
    end

    // Read channel
    rd_state_t                 r_state, r_next;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    idx_t                      r_idx;
    logic [7:0]                r_len;
    logic [8:0]                r_issued;
    logic [1:0]                r_burst, r_resp, sk_cnt;
    logic                      ar_hs, r_pop, r_issue, vld_p1, last_p1;
    logic [DATA_WIDTH-1:0]     ram_rdata, push_data, sk_data0, sk_data1;
    logic                      sk_last0, sk_last1;

    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign r_pop     = s_axi_rvalid && s_axi_rready;
    assign r_issue   = (r_state == R_DATA) && !areset && (r_issued <= {1'b0, r_len}) &&
                       ((sk_cnt + {1'b0, vld_p1} - {1'b0, r_pop}) < 2'd2);
    assign push_data = (r_resp == RESP_DECERR) ? '0 : ram_rdata;

    always_ff @(posedge aclk) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (r_pop && sk_last0) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (r_state == R_IDLE) && !areset;
        s_axi_rvalid  = (sk_cnt != 2'd0) && !areset;
        s_axi_rid     = s_axi_rvalid ? r_id : '0;
        s_axi_rdata   = s_axi_rvalid ? sk_data0 : '0;
        s_axi_rresp   = s_axi_rvalid ? r_resp : RESP_OKAY;
        s_axi_rlast   = s_axi_rvalid && sk_last0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_p1 <= 1'b0;
            sk_cnt <= 2'd0;
        end else begin
            vld_p1 <= r_issue;
            sk_cnt <= sk_cnt + {1'b0, vld_p1} - {1'b0, r_pop};
        end
    end

    // RAM issue stage, then skid buffer (entry 0 is the head driving R)
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_id     <= s_axi_arid;
            r_idx    <= s_axi_araddr[ADDR_LSB +: MEM_DEPTH_LOG2];
            r_len    <= s_axi_arlen;
            r_burst  <= s_axi_arburst;
            r_resp   <= burst_resp(s_axi_araddr, s_axi_arburst, s_axi_arsize);
            r_issued <= '0;
        end else if (r_issue) begin
            r_issued <= r_issued + 9'd1;
            r_idx    <= next_idx(r_idx, r_burst);
        end
        if (r_issue) last_p1 <= (r_issued[7:0] == r_len);

        if (vld_p1 && (sk_cnt == 2'd0 || (sk_cnt == 2'd1 && r_pop))) begin
            sk_data0 <= push_data;
            sk_last0 <= last_p1;
        end else if (r_pop) begin
            sk_data0 <= sk_data1;
            sk_last0 <= sk_last1;
        end
        if (vld_p1 && sk_cnt == 2'd1 && !r_pop) begin
            sk_data1 <= push_data;
            sk_last1 <= last_p1;
        end
    end

    axi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (aclk),
        .we    (w_hs && w_ok),
        .waddr (w_idx),
        .wdata (s_axi_wdata),
        .wbe   (s_axi_wstrb),
        .re    (r_issue),
        .raddr (r_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_ddr_responder.sv
// Directed + randomized bench for axi_ddr_responder against a word-array memory model.
module tb_axi_ddr_responder;

    logic         aclk = 1'b0;
    logic         areset;
    logic [0:0]   s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [31:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]   s_axi_awlen, s_axi_arlen;
    logic [2:0]   s_axi_awsize, s_axi_arsize;
    logic [1:0]   s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [511:0] s_axi_wdata, s_axi_rdata;
    logic [63:0]  s_axi_wstrb;

    axi_ddr_responder dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 aclk = ~aclk;

    int           checks = 0;
    int           errors = 0;
    logic [511:0] mdl  [1024];
    logic [511:0] wdat [16];
    logic [63:0]  wstb [16];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Response a burst deserves from its address, burst type and size alone
    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [1:0] burst,
                                            input logic [2:0] size);
        if (addr >= 32'h0001_0000) return 2'b11;
        if (burst == 2'b10 || burst == 2'b11 || size != 3'd6) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
        int base = int'((addr / 64) % 1024);
        return (burst == 2'b00) ? base : (base + b) % 1024;
    endfunction

    task automatic fill_full(input int n);
        for (int b = 0; b < n; b++) begin
            wdat[b] = rand512();
            wstb[b] = '1;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int bad_beat, input int abort_at,
                            input logic id);
        logic [1:0] er;
        int n, idx;
        er = exp_resp(addr, burst, size);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len[7:0];
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin tick(); n++; end
        chk("aw_accept", 1'(n < 50), 1'b1);
        tick();
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s_axi_wdata = wdat[b]; s_axi_wstrb = wstb[b];
            s_axi_wlast = (b == len) ^ (b == bad_beat); s_axi_wvalid = 1'b1;
            if (b == abort_at) begin
                areset = 1'b1;
                tick();
                s_axi_wvalid = 1'b0;
                chk("rst_bvalid", s_axi_bvalid, 1'b0);
                chk("rst_awready_low", s_axi_awready, 1'b0);
                tick();
                areset = 1'b0;
                tick();
                chk("rst_awready_back", s_axi_awready, 1'b1);
                chk("rst_bvalid_after", s_axi_bvalid, 1'b0);
                return;
            end
            n = 0;
            while (!s_axi_wready && n < 50) begin tick(); n++; end
            chk("w_accept", 1'(n < 50), 1'b1);
            if (er == 2'b00) begin
                idx = beat_idx(addr, burst, b);
                for (int k = 0; k < 64; k++)
                    if (wstb[b][k]) mdl[idx][k*8 +: 8] = wdat[b][k*8 +: 8];
            end
            tick();
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        chk("b_timing", s_axi_bvalid, 1'b1);
        if (er == 2'b00 && bad_beat >= 0) er = 2'b10;
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin tick(); n++; end
        chk("bresp", s_axi_bresp, er);
        chk("bid", s_axi_bid, id);
        tick();
        s_axi_bready = 1'b0;
        chk("b_done", s_axi_bvalid, 1'b0);
        chk("aw_idle", s_axi_awready, 1'b1);
    endtask

    // mode 0: rready always 1; mode 1: 1,0,0 repeating; mode 2: random
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int mode, input logic id);
        logic [1:0]   er;
        logic [511:0] hd;
        logic         hl, stalled;
        int n, got, c, first, lastc;
        er = exp_resp(addr, burst, size);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len[7:0];
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin tick(); n++; end
        chk("ar_accept", 1'(n < 50), 1'b1);
        tick();
        s_axi_arvalid = 1'b0;
        got = 0; c = 0; first = -1; lastc = -1; stalled = 1'b0; hd = '0; hl = 1'b0;
        while (got <= len && c < 400) begin
            s_axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((c % 3) == 0) : 1'($urandom_range(0, 1));
            if (s_axi_rvalid) begin
                if (first < 0) first = c;
                if (stalled) begin
                    chk("r_hold_data", s_axi_rdata, hd);
                    chk("r_hold_last", s_axi_rlast, hl);
                end
                if (s_axi_rready) begin
                    if (er == 2'b11) chk("r_data_decerr", s_axi_rdata, 512'd0);
                    else if (er == 2'b00) chk("r_data", s_axi_rdata, mdl[beat_idx(addr, burst, got)]);
                    chk("r_last", s_axi_rlast, 1'(got == len));
                    chk("r_resp", s_axi_rresp, er);
                    chk("r_id", s_axi_rid, id);
                    got++; lastc = c; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; hd = s_axi_rdata; hl = s_axi_rlast;
                end
            end
            tick();
            c++;
        end
        s_axi_rready = 1'b0;
        chk("r_count", got, len + 1);
        chk("r_latency", first, 2);
        chk("r_no_extra", s_axi_rvalid, 1'b0);
        if (mode == 0) chk("r_rate", lastc, 2 + len);
    endtask

    initial begin
        logic [511:0] v0, v1;
        int n, base, len;

        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_rready = 1'b0;

        // Reset: valids held high must not be accepted
        areset = 1'b1; s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        repeat (3) tick();
        chk("rst_awready", s_axi_awready, 1'b0);
        chk("rst_arready", s_axi_arready, 1'b0);
        chk("rst_wready", s_axi_wready, 1'b0);
        chk("rst_bvalid0", s_axi_bvalid, 1'b0);
        chk("rst_rvalid", s_axi_rvalid, 1'b0);
        chk("rst_rdata", s_axi_rdata, 512'd0);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        areset = 1'b0;
        tick();
        chk("post_rst_awready", s_axi_awready, 1'b1);
        chk("post_rst_arready", s_axi_arready, 1'b1);

        // Basic burst write then read back
        fill_full(4);
        do_write(32'h40, 3, 2'b01, 3'd6, -1, -1, 1'b1);
        do_read(32'h40, 3, 2'b01, 3'd6, 0, 1'b1);

        // Partial strobe over a word of 0xAA
        wdat[0] = {16{32'hAAAA_AAAA}}; wstb[0] = '1;
        do_write(10 * 64, 0, 2'b01, 3'd6, -1, -1, 1'b0);
        wdat[0] = rand512(); wstb[0] = 64'hF;
        do_write(10 * 64, 0, 2'b01, 3'd6, -1, -1, 1'b0);
        do_read(10 * 64, 0, 2'b01, 3'd6, 0, 1'b0);

        // Backpressure on an 8-beat read
        fill_full(8);
        do_write(20 * 64, 7, 2'b01, 3'd6, -1, -1, 1'b0);
        do_read(20 * 64, 7, 2'b01, 3'd6, 1, 1'b1);

        // Error responses
        do_read(32'h0001_0000, 2, 2'b01, 3'd6, 0, 1'b0);
        fill_full(2);
        do_write(30 * 64, 1, 2'b01, 3'd6, 0, -1, 1'b1);
        do_write(31 * 64, 0, 2'b10, 3'd6, -1, -1, 1'b0);
        do_write(32 * 64, 0, 2'b01, 3'd5, -1, -1, 1'b0);
        do_write(32'h0002_0000, 1, 2'b01, 3'd6, -1, -1, 1'b1);
        do_read(31 * 64, 1, 2'b10, 3'd6, 2, 1'b0);

        // FIXED burst keeps hitting one word
        fill_full(3);
        do_write(50 * 64, 2, 2'b00, 3'd6, -1, -1, 1'b0);
        do_read(50 * 64, 2, 2'b00, 3'd6, 0, 1'b0);

        // Same-cycle read and write of idx 5 returns the old word
        fill_full(1);
        do_write(5 * 64, 0, 2'b01, 3'd6, -1, -1, 1'b0);
        v0 = mdl[5]; v1 = rand512();
        s_axi_awid = 1'b0; s_axi_awaddr = 5 * 64; s_axi_awlen = 8'd0; s_axi_awsize = 3'd6; s_axi_awburst = 2'b01;
        s_axi_arid = 1'b0; s_axi_araddr = 5 * 64; s_axi_arlen = 8'd0; s_axi_arsize = 3'd6; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        chk("conc_ready", {s_axi_awready, s_axi_arready}, 2'b11);
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_wdata = v1; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; mdl[5] = v1;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin tick(); n++; end
        chk("conc_old", s_axi_rdata, v0);
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin tick(); n++; end
        chk("conc_bresp", s_axi_bresp, 2'b00);
        tick();
        s_axi_bready = 1'b0;
        do_read(5 * 64, 0, 2'b01, 3'd6, 0, 1'b0);

        // INCR wraps from the top word to word 0
        fill_full(2);
        do_write(1023 * 64, 1, 2'b01, 3'd6, -1, -1, 1'b1);
        do_read(0, 0, 2'b01, 3'd6, 0, 1'b0);
        do_read(1023 * 64, 1, 2'b01, 3'd6, 2, 1'b1);

        // Reset during beat 2 of a write
        fill_full(4);
        do_write(40 * 64, 3, 2'b01, 3'd6, -1, -1, 1'b0);
        fill_full(4);
        do_write(40 * 64, 3, 2'b01, 3'd6, -1, 2, 1'b1);
        do_read(40 * 64, 3, 2'b01, 3'd6, 2, 1'b0);

        // Random bursts: full fill, random-strobe overwrite, random-backpressure read
        for (int it = 0; it < 4; it++) begin
            base = $urandom_range(100, 900);
            len  = $urandom_range(0, 7);
            fill_full(len + 1);
            do_write(base * 64, len, 2'b01, 3'd6, -1, -1, 1'b0);
            for (int b = 0; b <= len; b++) begin
                wdat[b] = rand512();
                wstb[b] = {$urandom, $urandom};
            end
            do_write(base * 64, len, 2'b01, 3'd6, -1, -1, 1'b1);
            do_read(base * 64, len, 2'b01, 3'd6, 2, 1'(it & 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
